// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: RV32 opcodes,
// forwarding-select codes, FSM states and the source-use decode.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_ACC = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_MEMWAIT = 2'b10
    } state_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } src_use_t;

    // LUI/AUIPC/JAL and unknown opcodes read no registers.
    function automatic src_use_t src_use(input logic [6:0] opcode);
        src_use_t u;
        u = '0;
        case (opcode)
            OP_JALR, OP_LOAD, OP_IMM: u.rs1 = 1'b1;
            OP_BRANCH, OP_STORE, OP_OP: begin
                u.rs1 = 1'b1;
                u.rs2 = 1'b1;
            end
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW detection: decodes which sources the decode instruction
// reads and compares them against in-flight writers. Mode set by PIPE_HAZARD_FWD_EN.
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr_de,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic [REG_AW-1:0] acc_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              exe_wb,
    input  logic              acc_wb,
    input  logic              wb_wb,
    input  logic              exe_is_load,
    output logic              hazard,
    output fwd_sel_t          fwd_a_nxt,
    output fwd_sel_t          fwd_b_nxt
);

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    src_use_t          use_de;
    logic              a_exe, a_acc, a_wb;
    logic              b_exe, b_acc, b_wb;
    logic              unused_instr;

    assign rs1    = REG_AW'(instr_de[19:15]);
    assign rs2    = REG_AW'(instr_de[24:20]);
    assign use_de = de_valid ? src_use(instr_de[6:0]) : '0;

    assign unused_instr = ^{instr_de[31:25], instr_de[14:7]};

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic hit(input logic used, input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rd, input logic wr);
        return used && wr && (rs != '0) && (rs == rd);
    endfunction

    assign a_exe = hit(use_de.rs1, rs1, exe_rd, exe_wb);
    assign a_acc = hit(use_de.rs1, rs1, acc_rd, acc_wb);
    assign a_wb  = hit(use_de.rs1, rs1, wb_rd,  wb_wb);
    assign b_exe = hit(use_de.rs2, rs2, exe_rd, exe_wb);
    assign b_acc = hit(use_de.rs2, rs2, acc_rd, acc_wb);
    assign b_wb  = hit(use_de.rs2, rs2, wb_rd,  wb_wb);

`ifdef PIPE_HAZARD_FWD_EN
    logic unused_wb;
    assign unused_wb = a_wb | b_wb;

    // Only a load in EXE cannot be bypassed; its data appears one stage later.
    assign hazard    = exe_is_load && (a_exe || b_exe);
    // Selects are captured now but used next cycle, when EXE has moved to ACC
    // and ACC has moved to WB.
    assign fwd_a_nxt = a_exe ? FWD_ACC : (a_acc ? FWD_WB : FWD_RF);
    assign fwd_b_nxt = b_exe ? FWD_ACC : (b_acc ? FWD_WB : FWD_RF);
`else
    logic unused_load;
    assign unused_load = exe_is_load;

    assign hazard    = a_exe | a_acc | a_wb | b_exe | b_acc | b_wb;
    assign fwd_a_nxt = FWD_RF;
    assign fwd_b_nxt = FWD_RF;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush generation, registered forward
// selects and stall-cycle counter. Bypassing enabled by PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_de,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic [REG_AW-1:0] acc_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              exe_wb,
    input  logic              acc_wb,
    input  logic              wb_wb,
    input  logic              exe_is_load,
    input  logic              br_taken_exe,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    output logic              stall_if,
    output logic              stall_de,
    output logic              flush_de,
    output logic              flush_exe,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_t   state;
    logic     hazard;
    fwd_sel_t fwd_a_nxt;
    fwd_sel_t fwd_b_nxt;
    logic     freeze;
    logic     do_flush;
    logic     do_stall;

    pipe_hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .instr_de    (instr_de),
        .de_valid    (de_valid),
        .exe_rd      (exe_rd),
        .acc_rd      (acc_rd),
        .wb_rd       (wb_rd),
        .exe_wb      (exe_wb),
        .acc_wb      (acc_wb),
        .wb_wb       (wb_wb),
        .exe_is_load (exe_is_load),
        .hazard      (hazard),
        .fwd_a_nxt   (fwd_a_nxt),
        .fwd_b_nxt   (fwd_b_nxt)
    );

    // Priority: memory freeze, then taken branch, then data hazard. The ack
    // cycle is a normal cycle, so a branch held through the freeze acts there.
    always_comb begin
        freeze   = !dmem_ack && (dmem_req || (state == ST_MEMWAIT));
        do_flush = !freeze && br_taken_exe;
        do_stall = !freeze && !br_taken_exe && hazard && (state != ST_LDSTALL);
    end

    // Outputs are gated by rst so they take reset values in the same cycle.
    assign stall_if  = !rst && (freeze || do_stall);
    assign stall_de  = !rst && (freeze || do_stall);
    assign flush_de  = !rst && do_flush;
    assign flush_exe = !rst && (do_flush || do_stall);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (freeze) begin
            state <= ST_MEMWAIT;
        end else if (do_stall && FWD_EN) begin
            state <= ST_LDSTALL;
        end else begin
            state <= ST_RUN;
        end
    end

    // A bubble entering EXE clears the selects; a freeze holds them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (flush_exe) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (!stall_de) begin
            fwd_a_sel <= fwd_a_nxt;
            fwd_b_sel <= fwd_b_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expectations follow
// PIPE_HAZARD_FWD_EN. Counter width is reduced to 4 to reach saturation.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CNT_W = 4;
    localparam int CNT_MAX = 15;

    // {stall_if, stall_de, flush_de, flush_exe}
    localparam logic [3:0] CTL_NONE   = 4'b0000;
    localparam logic [3:0] CTL_STALL  = 4'b1101;
    localparam logic [3:0] CTL_FREEZE = 4'b1100;
    localparam logic [3:0] CTL_FLUSH  = 4'b0011;

    logic             clk;
    logic             rst;
    logic [31:0]      instr_de;
    logic             de_valid;
    logic [4:0]       exe_rd, acc_rd, wb_rd;
    logic             exe_wb, acc_wb, wb_wb;
    logic             exe_is_load;
    logic             br_taken_exe;
    logic             dmem_req;
    logic             dmem_ack;
    logic             stall_if, stall_de, flush_de, flush_exe;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    int total;
    int bad;
    int exp_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_de     (instr_de),
        .de_valid     (de_valid),
        .exe_rd       (exe_rd),
        .acc_rd       (acc_rd),
        .wb_rd        (wb_rd),
        .exe_wb       (exe_wb),
        .acc_wb       (acc_wb),
        .wb_wb        (wb_wb),
        .exe_is_load  (exe_is_load),
        .br_taken_exe (br_taken_exe),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .stall_if     (stall_if),
        .stall_de     (stall_de),
        .flush_de     (flush_de),
        .flush_exe    (flush_exe),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] op_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] with_op(input logic [31:0] w, input logic [6:0] op);
        logic [31:0] r;
        r = w;
        r[6:0] = op;
        return r;
    endfunction

    task automatic idle();
        instr_de = 32'h0000_0013;
        de_valid = 1'b0;
        exe_rd = 5'd0; acc_rd = 5'd0; wb_rd = 5'd0;
        exe_wb = 1'b0; acc_wb = 1'b0; wb_wb = 1'b0;
        exe_is_load = 1'b0;
        br_taken_exe = 1'b0;
        dmem_req = 1'b0;
        dmem_ack = 1'b0;
    endtask

    // Advance one clock; the bench counter model mirrors a saturating count.
    task automatic cyc(input bit stalled);
        if (stalled && exp_cnt != CNT_MAX) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic decode_load_use();
        exe_rd = 5'd7; exe_wb = 1'b1; exe_is_load = 1'b1;
        instr_de = op_r(5'd1, 5'd7, 5'd2); de_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE || {fwd_a_sel, fwd_b_sel} !== 4'b0000
            || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_hold got ctl=%b fwd=%b cnt=%0d want ctl=0000 fwd=0000 cnt=0",
                     {stall_if, stall_de, flush_de, flush_exe}, {fwd_a_sel, fwd_b_sel}, stall_cnt);
        end
        rst = 1'b0;
        cyc(0);
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE || {fwd_a_sel, fwd_b_sel} !== 4'b0000
            || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_release got ctl=%b fwd=%b cnt=%0d want ctl=0000 fwd=0000 cnt=0",
                     {stall_if, stall_de, flush_de, flush_exe}, {fwd_a_sel, fwd_b_sel}, stall_cnt);
        end
    endtask

    task automatic test_fwd_alu();
        logic [3:0] ctl;
        logic [3:0] fwd;
        idle();
        exe_rd = 5'd3; exe_wb = 1'b1;
        instr_de = op_r(5'd5, 5'd3, 5'd4); de_valid = 1'b1;
        #1;
        ctl = FWD ? CTL_NONE : CTL_STALL;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== ctl) begin
            bad++;
            $display("FAIL alu_exe_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, ctl);
        end
        cyc(!FWD);
        fwd = FWD ? 4'b0100 : 4'b0000;
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== fwd) begin
            bad++;
            $display("FAIL alu_exe_fwd got=%b want=%b", {fwd_a_sel, fwd_b_sel}, fwd);
        end
        exe_wb = 1'b0; acc_rd = 5'd3; acc_wb = 1'b1;
        instr_de = op_r(5'd6, 5'd2, 5'd3);
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== ctl) begin
            bad++;
            $display("FAIL alu_acc_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, ctl);
        end
        cyc(!FWD);
        fwd = FWD ? 4'b0010 : 4'b0000;
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== fwd) begin
            bad++;
            $display("FAIL alu_acc_fwd got=%b want=%b", {fwd_a_sel, fwd_b_sel}, fwd);
        end
        idle();
        cyc(0);
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            bad++;
            $display("FAIL alu_fwd_clear got=%b want=0000", {fwd_a_sel, fwd_b_sel});
        end
    endtask

    task automatic test_load_use();
        logic [3:0] ctl;
        logic [3:0] fwd;
        idle();
        decode_load_use();
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_STALL) begin
            bad++;
            $display("FAIL ld_detect_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_STALL);
        end
        cyc(1);
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            bad++;
            $display("FAIL ld_bubble_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel});
        end
        // Load has moved to ACC; EXE holds the bubble.
        exe_rd = 5'd0; exe_wb = 1'b0; exe_is_load = 1'b0;
        acc_rd = 5'd7; acc_wb = 1'b1;
        #1;
        ctl = FWD ? CTL_NONE : CTL_STALL;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== ctl) begin
            bad++;
            $display("FAIL ld_acc_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, ctl);
        end
        cyc(!FWD);
        fwd = FWD ? 4'b1000 : 4'b0000;
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== fwd) begin
            bad++;
            $display("FAIL ld_acc_fwd got=%b want=%b", {fwd_a_sel, fwd_b_sel}, fwd);
        end
        acc_rd = 5'd0; acc_wb = 1'b0; wb_rd = 5'd7; wb_wb = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== ctl) begin
            bad++;
            $display("FAIL ld_wb_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, ctl);
        end
        cyc(!FWD);
        idle();
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL ld_clear_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        cyc(0);
        total++;
        if (stall_cnt !== exp_cnt[CNT_W-1:0]) begin
            bad++;
            $display("FAIL ld_cnt got=%0d want=%0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_x0_and_decode();
        idle();
        exe_rd = 5'd0; exe_wb = 1'b1; exe_is_load = 1'b1;
        instr_de = op_r(5'd5, 5'd0, 5'd0); de_valid = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL x0_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        cyc(0);
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            bad++;
            $display("FAIL x0_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel});
        end
        // LUI carries 3 in the rs1 field but reads no register.
        exe_rd = 5'd3;
        instr_de = with_op(op_r(5'd3, 5'd3, 5'd3), 7'b0110111);
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL lui_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        // OP-IMM reads only rs1; rs2 field matching must be ignored.
        instr_de = with_op(op_r(5'd4, 5'd0, 5'd3), 7'b0010011);
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL opimm_rs2_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        instr_de = op_r(5'd1, 5'd3, 5'd3); de_valid = 1'b0;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL bubble_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        // STORE reads rs2: load-use through rs2.
        instr_de = with_op(op_r(5'd0, 5'd0, 5'd3), 7'b0100011); de_valid = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_STALL) begin
            bad++;
            $display("FAIL store_rs2_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_STALL);
        end
        cyc(1);
        idle();
        cyc(0);
    endtask

    task automatic test_branch();
        idle();
        decode_load_use();
        br_taken_exe = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_FLUSH) begin
            bad++;
            $display("FAIL br_over_ld_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_FLUSH);
        end
        cyc(0);
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            bad++;
            $display("FAIL br_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel});
        end
        // Still in RUN: the same load-use now stalls.
        br_taken_exe = 1'b0;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_STALL) begin
            bad++;
            $display("FAIL br_then_ld_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_STALL);
        end
        cyc(1);
        idle();
        cyc(0);
        dmem_req = 1'b1; br_taken_exe = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_FREEZE) begin
            bad++;
            $display("FAIL br_in_freeze_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_FREEZE);
        end
        cyc(1);
        dmem_ack = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_FLUSH) begin
            bad++;
            $display("FAIL br_at_ack_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_FLUSH);
        end
        cyc(0);
        idle();
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL br_after_ack_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        cyc(0);
    endtask

    task automatic test_memwait();
        logic [3:0] fwd;
        idle();
        exe_rd = 5'd9; exe_wb = 1'b1;
        instr_de = op_r(5'd1, 5'd9, 5'd0); de_valid = 1'b1;
        #1;
        cyc(!FWD);
        fwd = FWD ? 4'b0100 : 4'b0000;
        idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_FREEZE) begin
                bad++;
                $display("FAIL mem_freeze_ctl cycle=%0d got=%b want=%b", i,
                         {stall_if, stall_de, flush_de, flush_exe}, CTL_FREEZE);
            end
            cyc(1);
        end
        total++;
        if ({fwd_a_sel, fwd_b_sel} !== fwd) begin
            bad++;
            $display("FAIL mem_fwd_hold got=%b want=%b", {fwd_a_sel, fwd_b_sel}, fwd);
        end
        dmem_ack = 1'b1;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL mem_ack_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        cyc(0);
        idle();
        total++;
        if (stall_cnt !== exp_cnt[CNT_W-1:0]) begin
            bad++;
            $display("FAIL mem_cnt got=%0d want=%0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        idle();
        dmem_req = 1'b1;
        repeat (20) cyc(1);
        dmem_ack = 1'b1;
        cyc(0);
        idle();
        cyc(0);
        total++;
        if (stall_cnt !== 4'd15 || exp_cnt != CNT_MAX) begin
            bad++;
            $display("FAIL cnt_saturate got=%0d want=15 (model=%0d)", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_memwait();
        idle();
        dmem_req = 1'b1;
        cyc(1);
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_FREEZE) begin
            bad++;
            $display("FAIL rstmw_pre_ctl got=%b want=%b", {stall_if, stall_de, flush_de, flush_exe}, CTL_FREEZE);
        end
        rst = 1'b1;
        exp_cnt = 0;
        #1;
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE || {fwd_a_sel, fwd_b_sel} !== 4'b0000
            || stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL rstmw_async got ctl=%b fwd=%b cnt=%0d want ctl=0000 fwd=0000 cnt=0",
                     {stall_if, stall_de, flush_de, flush_exe}, {fwd_a_sel, fwd_b_sel}, stall_cnt);
        end
        dmem_req = 1'b0;
        cyc(0);
        rst = 1'b0;
        #1;
        // Ack is still low: a surviving MEMWAIT would keep freezing.
        total++;
        if ({stall_if, stall_de, flush_de, flush_exe} !== CTL_NONE) begin
            bad++;
            $display("FAIL rstmw_run_ctl got=%b want=0000", {stall_if, stall_de, flush_de, flush_exe});
        end
        cyc(0);
        total++;
        if (stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL rstmw_cnt got=%0d want=0", stall_cnt);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_x0_and_decode();
        test_branch();
        test_memwait();
        test_saturate();
        test_reset_memwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
